amp_i2c_master: RTL
===================

# amp_i2c_master

I2C single-register initiator that configures the external amplifier over the `amp_i2c_*` pins, which the chip's own I2C target interface cannot drive. It sits in the top level beside the register bank and serves the opposite end of the I2C protocol from the existing target. Register-bank fields or a future boot sequencer issue one write or one read per request through a req/busy/done handshake. It generates START, repeated START and STOP conditions, shifts bytes MSB-first, checks the target's ACKs and reports NACK errors.

## Interface
- `CLK_DIV`, default 32: `clk` cycles per quarter SCL period; legal range 2..255; SCL = f_clk/(4·CLK_DIV).
- `clk` in 1: system clock; everything is synchronous to its rising edge.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `req` in 1: start-transaction pulse; sampled only while `busy`=0.
- `rnw` in 1: 1 = register read, 0 = register write.
- `dev_addr` in 7: 7-bit target address.
- `reg_addr` in 8: target register address.
- `wdata` in 8: write data.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse at transaction end.
- `ack_err` out 1: last transaction saw a NACK; valid when `done`=1; held until next accept.
- `rdata` out 8: read result; updated only on a successful read.
- `scl` out 1: SCL drive; 1 = released, 0 = pull low.
- `sdao` out 1: SDA drive; 1 = released, 0 = pull low.
- `sdai` in 1: SDA pad level; synchronised internally through 2 flops.

## Operation
- Reset values: `scl`=1, `sdao`=1, `busy`=0, `done`=0, `ack_err`=0, `rdata`=0x00, FSM in IDLE, divider and bit counter at 0.
- Accept: `req`=1 while in IDLE captures `rnw`, `dev_addr`, `reg_addr` and `wdata`. `req` is ignored while `busy`=1.
- Write sequence: START, {dev_addr,0}, ACK, reg_addr, ACK, wdata, ACK, STOP.
- Read sequence: START, {dev_addr,0}, ACK, reg_addr, ACK, RSTART, {dev_addr,1}, ACK, 8 data bits, master NACK (SDA released), STOP.
- FSM states: IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_NACK, STOP.
  - A phase register selects the next byte: DEV_W, REG, WDATA, DEV_R.
  - A 3-bit counter indexes bits 7 down to 0.
- Bit cell is 4 quarters: Q0 SCL low, SDA updated at Q0 entry; Q1 and Q2 SCL high; Q3 SCL low.
- Sampling: `sdai` (synchronised) is sampled on the last cycle of Q1.
- START and RSTART: Q0 SDA=1 and SCL low (RSTART only); Q1 SCL=1; Q2 SDA=0; Q3 SCL=0.
- STOP: Q0 SDA=0; Q1 SCL=1; Q2 and Q3 SDA=1.
- NACK handling: sampled 1 in any RX_ACK sets `ack_err`=1 and jumps straight to STOP; remaining bytes are skipped and `rdata` is unchanged.
- RX_BYTE shifts MSB-first; `rdata` loads at the end of TX_NACK.
- Reset asserted mid-transaction releases both lines on the next edge; no STOP is generated.

## Timing
- Accept on cycle T; `busy`=1 from T+1.
- Completion: `done`=1 and `busy`=0 in the same cycle, at T+1+N·CLK_DIV.
  - Write: N=116 quarters.
  - Read: N=156 quarters.
  - NACK on the device address: N=44 quarters.
- A new `req` may be accepted in the cycle after `done`.
- Effective `sdai` sampling latency is 2 clk cycles; CLK_DIV≥2 guarantees it lands within Q1.
- No clock stretching and no multi-master arbitration.

## Structure
- `toi2s_pkg` holds:
  - the FSM state enum `i2cm_state_t`;
  - the byte-phase enum `i2cm_phase_t`;
  - the constants `I2C_WR`=0 and `I2C_RD`=1;
  - the quarter-count constants 116, 156 and 44 for benches.
- One sub-module, `i2cm_quarter_gen`: divider emitting a one-cycle `qtick` every CLK_DIV cycles plus a 2-bit quarter index. It restarts on accept.

## Test plan
- Write with CLK_DIV=4: dev 0x2C, reg 0x03, wdata 0xA5, ACKing target model → model logs W 0x58,0x03,0xA5; `done` at T+1+464; `ack_err`=0.
- Read with CLK_DIV=4: dev 0x2C, reg 0x10, target returns 0x3C → bytes 0x58,0x10, RSTART, 0x59; master NACKs; `rdata`=0x3C; `done` at T+1+624.
- Absent device: model never ACKs → STOP right after the address; `ack_err`=1; `done` at T+1+176; `rdata` keeps its prior value.
- `req` pulsed while busy → ignored; a second `req` the cycle after `done` → accepted, `busy`=1 next cycle.
- Reset asserted during a data bit → next cycle `scl`=1, `sdao`=1, `busy`=0; the next transaction completes normally.
- Protocol checker on every run: SDA never changes while SCL is high except at START, RSTART and STOP; SCL period equals 4·CLK_DIV.

Source files
------------

// File: rtl/toi2s_pkg.sv
// ---------------------------------------------------------------------------
// toi2s_pkg
// Shared types and constants for the amplifier I2C initiator.
//   i2cm_state_t : bit-level FSM states
//   i2cm_phase_t : which byte of the transaction is on the wire
//   I2C_WR/I2C_RD: R/W bit values appended to the 7-bit device address
//   QTR_*        : quarter-bit counts per transaction type (done latency / CLK_DIV)
// ---------------------------------------------------------------------------
package toi2s_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    TX_BYTE,
    RX_ACK,
    RSTART,
    RX_BYTE,
    TX_NACK,
    STOP
  } i2cm_state_t;

  typedef enum logic [1:0] {
    DEV_W,
    REG,
    WDATA,
    DEV_R
  } i2cm_phase_t;

  localparam logic I2C_WR = 1'b0;
  localparam logic I2C_RD = 1'b1;

  localparam int unsigned QTR_WRITE = 116;
  localparam int unsigned QTR_READ  = 156;
  localparam int unsigned QTR_NACK  = 44;

  // Byte the initiator shifts out for a given phase.
  function automatic logic [7:0] phase_byte(input i2cm_phase_t ph,
                                            input logic [6:0]  dev,
                                            input logic [7:0]  rg,
                                            input logic [7:0]  wd);
    case (ph)
      DEV_W:   return {dev, I2C_WR};
      REG:     return rg;
      WDATA:   return wd;
      default: return {dev, I2C_RD};
    endcase
  endfunction

endpackage

// File: rtl/i2cm_quarter_gen.sv
// ---------------------------------------------------------------------------
// i2cm_quarter_gen
// Divides clk into quarter-bit ticks for the I2C initiator.
//   clk, reset  : system clock, synchronous active-high reset
//   restart_i   : zero the divider and quarter index (transaction accept)
//   qtick_o     : one-cycle pulse on the last clk of every quarter
//   quarter_o   : index of the current quarter within a bit cell (0..3)
// ---------------------------------------------------------------------------
module i2cm_quarter_gen #(
  parameter int unsigned CLK_DIV = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart_i,
  output logic       qtick_o,
  output logic [1:0] quarter_o
);

  logic [7:0] cnt_q, cnt_d;
  logic [1:0] qtr_q, qtr_d;

  assign qtick_o   = (cnt_q == 8'(CLK_DIV - 1));
  assign quarter_o = qtr_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    cnt_d = cnt_q + 8'd1;
    qtr_d = qtr_q;
    if (restart_i) begin
      cnt_d = '0;
      qtr_d = '0;
    end else if (qtick_o) begin
      cnt_d = '0;
      qtr_d = qtr_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together from pre-edge values.
    if (reset) begin
      cnt_q <= '0;
      qtr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      qtr_q <= qtr_d;
    end
  end

endmodule

// File: rtl/amp_i2c_master.sv
// ---------------------------------------------------------------------------
// amp_i2c_master
// Single-register I2C initiator for the external amplifier.
//   clk, reset          : system clock, synchronous active-high reset
//   req/rnw             : start pulse (taken only when idle), 1 = read
//   dev_addr/reg_addr   : 7-bit target address, register address
//   wdata / rdata       : write byte / byte returned by a successful read
//   busy, done, ack_err : in progress, one-cycle end pulse, NACK seen
//   scl, sdao           : open-drain drives (1 = released, 0 = pull low)
//   sdai                : SDA pad level, synchronised internally
// A bit cell is four quarters: Q0 SCL low (SDA moves), Q1/Q2 SCL high, Q3 low.
// Line drives are decoded from state and quarter, then registered so the pads
// see glitch-free levels; both lines shift by the same cycle.
// ---------------------------------------------------------------------------
module amp_i2c_master
  import toi2s_pkg::*;
#(
  parameter int unsigned CLK_DIV = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       rnw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl,
  output logic       sdao,
  input  logic       sdai
);

  i2cm_state_t state_q, state_d;
  i2cm_phase_t phase_q, phase_d;
  logic [2:0]  bit_q, bit_d;
  logic        rnw_q, rnw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ack_err_q, ack_err_d;
  logic        done_q, done_d;
  logic        scl_q, scl_d;
  logic        sdao_q, sdao_d;
  logic        sda_meta_q, sda_sync_q;

  logic        accept, qtick, q_end, q_sample, scl_bit_cell;
  logic [1:0]  quarter;
  logic [7:0]  tx_byte;

  assign accept = (state_q == IDLE) && req;

  i2cm_quarter_gen #(.CLK_DIV(CLK_DIV)) u_qgen (
    .clk       (clk),
    .reset     (reset),
    .restart_i (accept),
    .qtick_o   (qtick),
    .quarter_o (quarter)
  );

  assign q_end        = qtick && (quarter == 2'd3);
  // Last cycle of Q1: SCL has been high long enough for the 2-flop sync.
  assign q_sample     = qtick && (quarter == 2'd1);
  assign scl_bit_cell = (quarter == 2'd1) || (quarter == 2'd2);
  assign tx_byte      = phase_byte(phase_q, dev_q, reg_q, wdata_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      sda_meta_q <= sdai;
      sda_sync_q <= sda_meta_q;
    end
  end

  // Transaction sequencing; every state lasts exactly one bit cell.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    rnw_d     = rnw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        state_d   = START;
        rnw_d     = rnw;
        dev_d     = dev_addr;
        reg_d     = reg_addr;
        wdata_d   = wdata;
        ack_err_d = 1'b0;
      end
      START: if (q_end) begin
        state_d = TX_BYTE;
        phase_d = DEV_W;
        bit_d   = 3'd7;
      end
      TX_BYTE: if (q_end) begin
        if (bit_q == 3'd0) state_d = RX_ACK;
        else               bit_d   = bit_q - 3'd1;
      end
      RX_ACK: begin
        if (q_sample && sda_sync_q) ack_err_d = 1'b1;
        if (q_end) begin
          bit_d = 3'd7;
          if (ack_err_q) begin
            state_d = STOP;   // any NACK abandons the remaining bytes
          end else begin
            case (phase_q)
              DEV_W: begin
                state_d = TX_BYTE;
                phase_d = REG;
              end
              REG: begin
                if (rnw_q == I2C_RD) begin
                  state_d = RSTART;
                end else begin
                  state_d = TX_BYTE;
                  phase_d = WDATA;
                end
              end
              WDATA:   state_d = STOP;
              default: state_d = RX_BYTE;
            endcase
          end
        end
      end
      RSTART: if (q_end) begin
        state_d = TX_BYTE;
        phase_d = DEV_R;
        bit_d   = 3'd7;
      end
      RX_BYTE: begin
        if (q_sample) rx_d = {rx_q[6:0], sda_sync_q};
        if (q_end) begin
          if (bit_q == 3'd0) state_d = TX_NACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      TX_NACK: if (q_end) begin
        state_d = STOP;
        rdata_d = rx_q;
      end
      STOP: if (q_end) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line levels for the current state/quarter.
  always_comb begin
    scl_d  = 1'b1;
    sdao_d = 1'b1;
    case (state_q)
      START: begin
        scl_d  = (quarter != 2'd3);
        sdao_d = ~quarter[1];           // SDA falls in Q2 with SCL high
      end
      RSTART: begin
        scl_d  = scl_bit_cell;
        sdao_d = ~quarter[1];
      end
      TX_BYTE: begin
        scl_d  = scl_bit_cell;
        sdao_d = tx_byte[bit_q];
      end
      RX_ACK, RX_BYTE, TX_NACK: scl_d = scl_bit_cell;
      STOP: begin
        scl_d  = (quarter != 2'd0);
        sdao_d = quarter[1];            // SDA rises in Q2 with SCL high
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= DEV_W;
      bit_q     <= '0;
      rnw_q     <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
      scl_q     <= 1'b1;
      sdao_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      rnw_q     <= rnw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
      scl_q     <= scl_d;
      sdao_q    <= sdao_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;
  assign scl     = scl_q;
  assign sdao    = sdao_q;

endmodule
